// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer FSM state encoding, ALU function codes
// and the default operand/function widths.
package alu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FUN_WIDTH  = 4;

  // Sequencer FSM states (2-bit encoding)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // ALU function codes
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_MUL    = 4'b0010;
  localparam logic [3:0] ALU_DIV    = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_NAND   = 4'b0110;
  localparam logic [3:0] ALU_NOR    = 4'b0111;
  localparam logic [3:0] ALU_XOR    = 4'b1000;
  localparam logic [3:0] ALU_XNOR   = 4'b1001;
  localparam logic [3:0] ALU_CMP_EQ = 4'b1010;
  localparam logic [3:0] ALU_CMP_GT = 4'b1011;
  localparam logic [3:0] ALU_CMP_LT = 4'b1100;
  localparam logic [3:0] ALU_SHR    = 4'b1101;
  localparam logic [3:0] ALU_SHL    = 4'b1110;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle for alu_cmd_sequencer: command handshake, ALU drive/return and
// result handshake plus the completed-operation counter.
//   slave  : the sequencer side
//   master : the environment (controller + ALU + result consumer) side
interface alu_cmd_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned CNT_WIDTH  = 16
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FUN_WIDTH-1:0]  cmd_fun;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  alu_en;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_out_valid;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_err;
  logic [CNT_WIDTH-1:0]  op_count;

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, res_ready,
    output cmd_ready, alu_a, alu_b, alu_fun, alu_en, res_valid, res_data, res_err,
           op_count
  );

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun, alu_en, res_valid, res_data, res_err,
           op_count
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to the shared ALU and
// returns its result on a valid/ready handshake.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - alu_cmd_sequencer_if.slave: cmd_* handshake in, alu_* drive out,
//          alu_out/alu_out_valid back, res_* handshake out, op_count out
// Optional feature: define ALU_SEQ_DIV0_CHECK_EN to short-circuit a divide
// by zero to an error result without touching the ALU.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FUN_WIDTH   = DEF_FUN_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input logic CLK,
  input logic RST,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned TCNT_WIDTH = $clog2(TIMEOUT_CYC) + 1;

  logic [1:0]            state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [DATA_WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q,   alu_fun_d;
  logic                  alu_en_q,    alu_en_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
  logic                  res_err_q,   res_err_d;
  logic [CNT_WIDTH-1:0]  op_count_q,  op_count_d;
  logic [TCNT_WIDTH-1:0] tcnt_q,      tcnt_d;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      op_count_q  <= op_count_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    alu_en_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    op_count_d  = op_count_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_fun_d   = bus.cmd_fun;
          alu_a_d     = bus.cmd_a;
          alu_b_d     = bus.cmd_b;
          cmd_ready_d = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
          if (bus.cmd_fun == FUN_WIDTH'(ALU_DIV) && bus.cmd_b == '0) begin
            state_d     = ST_HOLD;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            alu_en_d = 1'b1;
          end
`else
          state_d  = ST_ISSUE;
          alu_en_d = 1'b1;
`endif
        end
      end

      // alu_en is high for this single cycle
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end

      // Wait for the ALU, giving up after TIMEOUT_CYC cycles in this state
      ST_WAIT: begin
        if (bus.alu_out_valid) begin
          res_data_d  = bus.alu_out;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (tcnt_q == TCNT_WIDTH'(TIMEOUT_CYC - 1)) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          tcnt_d = tcnt_q + TCNT_WIDTH'(1);
        end
      end

      ST_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_WIDTH'(1);
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a small registered ALU model
// (one-cycle latency) that can be muted to force the timeout path.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 16;

  logic CLK;
  logic RST;
  bit   stub;
  int   n_chk;
  int   n_pass;

  alu_cmd_sequencer_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

  alu_cmd_sequencer #(
    .DATA_WIDTH (DW),
    .FUN_WIDTH  (FW),
    .TIMEOUT_CYC(4),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] alu_f(input logic [FW-1:0] f,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = a * b;
    case (f)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_MUL:    return p[DW-1:0];
      ALU_DIV:    return (b == 0) ? 8'hFF : a / b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_CMP_EQ: return (a == b) ? 8'd1 : 8'd0;
      default:    return 8'd0;
    endcase
  endfunction

  // Registered ALU model
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.alu_out_valid <= 1'b0;
      bus.alu_out       <= '0;
    end else begin
      bus.alu_out_valid <= bus.alu_en && !stub;
      if (bus.alu_en) bus.alu_out <= alu_f(bus.alu_fun, bus.alu_a, bus.alu_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Caller is at a negedge on entry; returns at a negedge.
  task automatic run_op(input string nm, input logic [FW-1:0] f,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int hold, input logic [DW-1:0] exp_data,
                        input logic exp_err, input int exp_lat, input int exp_en,
                        input int exp_cnt);
    int  lat;
    int  en;
    bit  seen;
    chk({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_fun   = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0;
    lat  = 0;
    en   = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.alu_en) begin
        en++;
        chk({nm, "_alu_ab"}, {16'd0, bus.alu_a, bus.alu_b}, {16'd0, a, b});
        chk({nm, "_alu_fun"}, 32'(bus.alu_fun), 32'(f));
      end
      if (bus.res_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_en_pulses"}, 32'(en), 32'(exp_en));
    chk({nm, "_data"}, 32'(bus.res_data), 32'(exp_data));
    chk({nm, "_err"}, 32'(bus.res_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({nm, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      chk({nm, "_hold_data"}, 32'(bus.res_data), 32'(exp_data));
      chk({nm, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      chk({nm, "_hold_count"}, 32'(bus.op_count), 32'(exp_cnt - 1));
    end
    bus.res_ready = 1'b1;
    @(posedge CLK);
    #1 bus.res_ready = 1'b0;
    @(negedge CLK);
    chk({nm, "_count"}, 32'(bus.op_count), 32'(exp_cnt));
    chk({nm, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    stub = 1'b0;
    RST = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_fun   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_alu_abf", {12'd0, bus.alu_fun, bus.alu_a, bus.alu_b}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    run_op("add", ALU_ADD, 8'h12, 8'h34, 0, 8'h46, 1'b0, 3, 1, 1);
    run_op("sub_hold", ALU_SUB, 8'd5, 8'd3, 5, 8'd2, 1'b0, 3, 1, 2);
    stub = 1'b1;
    run_op("timeout", ALU_ADD, 8'h01, 8'h02, 0, 8'h00, 1'b1, 6, 1, 3);
    stub = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
    run_op("div0", ALU_DIV, 8'h10, 8'h00, 0, 8'h00, 1'b1, 1, 0, 4);
`else
    run_op("div0", ALU_DIV, 8'h10, 8'h00, 0, 8'hFF, 1'b0, 3, 1, 4);
`endif

    // Reset while the sequencer sits in WAIT
    bus.cmd_valid = 1'b1;
    bus.cmd_fun   = ALU_MUL;
    bus.cmd_a     = 8'h13;
    bus.cmd_b     = 8'h11;
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_alu_en", 32'(bus.alu_en), 32'd0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_op_count", 32'(bus.op_count), 32'd0);
    chk("mid_rst_alu_abf", {12'd0, bus.alu_fun, bus.alu_a, bus.alu_b}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    run_op("b2b_and", ALU_AND, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 3, 1, 1);
    run_op("b2b_or", ALU_OR, 8'hF0, 8'h0F, 0, 8'hFF, 1'b0, 3, 1, 2);
    run_op("b2b_eq", ALU_CMP_EQ, 8'd7, 8'd7, 0, 8'd1, 1'b0, 3, 1, 3);
    run_op("mul_trunc", ALU_MUL, 8'h13, 8'h11, 0, 8'h43, 1'b0, 3, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
